// File: rtl/config_reg_rx_pkg.sv
// Shared definitions for the serial configuration receiver: register field
// positions, frame geometry and the receive FSM state type.
package cfg_pkg;

   localparam int CFG_W = 48;

   // Field positions inside the committed configuration register.
   localparam int CFD_DIS_LSB       = 0;
   localparam int CFD_DIS_W         = 30;
   localparam int TESTMODE_PEAK_HG  = 30;
   localparam int PULSER_HG_L       = 31;
   localparam int HOLES             = 32;
   localparam int FOUR_USEC_L       = 33;
   localparam int TESTMODE_CORE     = 34;
   localparam int TESTMODE_CSA      = 35;
   localparam int USE_EVEN_PULSER   = 36;
   localparam int TESTMODE_PEAK_EXT = 37;
   localparam int TESTMODE_SHAPER   = 38;
   localparam int USE_ODD_PULSER    = 39;
   localparam int CHIP_ID_LSB       = 40;
   localparam int CHIP_ID_W         = 8;

   // Received-bit counter: wide enough to tell 48 apart from overruns.
   localparam int             CNT_W   = 6;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } rx_state_e;

   // A frame is addressed to us when it carries our ID or the broadcast ID.
   function automatic logic id_match(input logic [CHIP_ID_W-1:0] id,
                                     input logic [CHIP_ID_W-1:0] mine,
                                     input logic [CHIP_ID_W-1:0] bcast);
      return (id == mine) || (id == bcast);
   endfunction

endpackage

// File: rtl/config_reg_rx_if.sv
// Pin-side and control-side signals of the configuration receiver.
// slave: the receiver itself; master: whoever drives the pins and uses the
// decoded controls.
interface config_reg_rx_if;
   import cfg_pkg::*;

   logic                 sinp;
   logic                 sclk;
   logic [CFG_W-1:0]     config_q;
   logic [CFD_DIS_W-1:0] cfd_disable;
   logic                 testmode_peak_hg;
   logic                 pulser_hg_l;
   logic                 holes;
   logic                 four_usec_l;
   logic                 testmode_core;
   logic                 testmode_csa;
   logic                 use_even_pulser;
   logic                 testmode_peak_ext;
   logic                 testmode_shaper;
   logic                 use_odd_pulser;
   logic [CHIP_ID_W-1:0] chip_id;
   logic                 cfg_valid;
   logic                 frame_err;

   modport slave (
      input  sinp, sclk,
      output config_q, cfd_disable, testmode_peak_hg, pulser_hg_l, holes,
             four_usec_l, testmode_core, testmode_csa, use_even_pulser,
             testmode_peak_ext, testmode_shaper, use_odd_pulser, chip_id,
             cfg_valid, frame_err
   );

   modport master (
      output sinp, sclk,
      input  config_q, cfd_disable, testmode_peak_hg, pulser_hg_l, holes,
             four_usec_l, testmode_core, testmode_csa, use_even_pulser,
             testmode_peak_ext, testmode_shaper, use_odd_pulser, chip_id,
             cfg_valid, frame_err
   );

endinterface

// File: rtl/config_reg_rx_pin_sync_edge.sv
// Two-flop synchroniser for asynchronous pins. The edge pin additionally
// gets an edge register and a rising-edge strobe; the data pins share the
// same synchroniser depth so they stay aligned with the strobe.
module pin_sync_edge #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              edge_pin_i,
   input  logic [DATA_W-1:0] data_pin_i,
   output logic              edge_rise_o,
   output logic [DATA_W-1:0] data_s_o
);

   logic              edge_s1_q, edge_s2_q, edge_prev_q;
   logic [DATA_W-1:0] data_s1_q, data_s2_q;

   // Synchronise all pins and remember the previous synchronised edge level.
   // NOTE: every clocked register uses non-blocking assignment so that all
   // flops sample the values from before the edge, as real hardware does.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         edge_s1_q   <= 1'b0;
         edge_s2_q   <= 1'b0;
         edge_prev_q <= 1'b0;
         data_s1_q   <= '0;
         data_s2_q   <= '0;
      end else begin
         edge_s1_q   <= edge_pin_i;
         edge_s2_q   <= edge_s1_q;
         edge_prev_q <= edge_s2_q;
         data_s1_q   <= data_pin_i;
         data_s2_q   <= data_s1_q;
      end
   end

   assign edge_rise_o = edge_s2_q & ~edge_prev_q;
   assign data_s_o    = data_s2_q;

endmodule

// File: rtl/config_reg_rx.sv
// Serial configuration receiver: oversamples sinp/sclk, shifts in a frame
// MSB first, and after an idle gap commits it to the configuration register
// when it is exactly CFG_W bits long and addressed to this chip.
module config_reg_rx
   import cfg_pkg::*;
#(
   parameter int unsigned          TIMEOUT   = 256,
   parameter logic [CHIP_ID_W-1:0] MY_ID     = 8'h00,
   parameter logic [CHIP_ID_W-1:0] BCAST_ID  = 8'hFF,
   parameter logic [CFG_W-1:0]     RESET_CFG = 48'h0001_0000_0000
) (
   input  logic            clk,
   input  logic            reset_l,
   config_reg_rx_if.slave  bus
);

   localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

   logic             sclk_rise;
   logic             sinp_s;

   rx_state_e        state_q;
   logic [CFG_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDLE_W-1:0] idle_q;
   logic [CFG_W-1:0] cfg_q;
   logic             cfg_valid_q;
   logic             frame_err_q;

   pin_sync_edge #(
      .DATA_W (1)
   ) u_sync (
      .clk         (clk),
      .reset_l     (reset_l),
      .edge_pin_i  (bus.sclk),
      .data_pin_i  (bus.sinp),
      .edge_rise_o (sclk_rise),
      .data_s_o    (sinp_s)
   );

   // Next shift-register contents and saturating bit count for a detected rise.
   // NOTE: every signal assigned here gets a value on every path so that no
   // latch is inferred.
   always_comb begin
      sr_d  = {sr_q[CFG_W-2:0], sinp_s};
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // Receive FSM: shift on each rise, close the frame after TIMEOUT idle clks,
   // then decide commit or discard in a single CHECK cycle.
   // NOTE: the shift register is reset along with the rest of the state; it is
   // a plain flop chain, not a RAM, so the reset costs nothing and keeps
   // simulation free of X.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         idle_q      <= '0;
         cfg_q       <= RESET_CFG;
         cfg_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         cfg_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q  <= '0;
               idle_q <= '0;
               if (sclk_rise) begin
                  sr_q    <= sr_d;
                  cnt_q   <= CNT_W'(1);
                  idle_q  <= TIMEOUT_V;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  sr_q   <= sr_d;
                  cnt_q  <= cnt_d;
                  idle_q <= TIMEOUT_V;
               end else if (idle_q <= IDLE_W'(1)) begin
                  // Counter reaches zero on this edge: the frame is closed.
                  idle_q  <= '0;
                  state_q <= CHECK;
               end else begin
                  idle_q <= idle_q - IDLE_W'(1);
               end
            end
            CHECK: begin
               // Rises arriving here are ignored; the sender's gap prevents them.
               if (cnt_q == CNT_W'(CFG_W) &&
                   id_match(sr_q[CHIP_ID_LSB +: CHIP_ID_W], MY_ID, BCAST_ID)) begin
                  cfg_q       <= sr_q;
                  cfg_valid_q <= 1'b1;
               end else begin
                  frame_err_q <= 1'b1;
               end
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Decoded controls are plain slices of the committed register, so they only
   // move when a whole frame is accepted.
   assign bus.config_q          = cfg_q;
   assign bus.cfd_disable       = cfg_q[CFD_DIS_LSB +: CFD_DIS_W];
   assign bus.testmode_peak_hg  = cfg_q[TESTMODE_PEAK_HG];
   assign bus.pulser_hg_l       = cfg_q[PULSER_HG_L];
   assign bus.holes             = cfg_q[HOLES];
   assign bus.four_usec_l       = cfg_q[FOUR_USEC_L];
   assign bus.testmode_core     = cfg_q[TESTMODE_CORE];
   assign bus.testmode_csa      = cfg_q[TESTMODE_CSA];
   assign bus.use_even_pulser   = cfg_q[USE_EVEN_PULSER];
   assign bus.testmode_peak_ext = cfg_q[TESTMODE_PEAK_EXT];
   assign bus.testmode_shaper   = cfg_q[TESTMODE_SHAPER];
   assign bus.use_odd_pulser    = cfg_q[USE_ODD_PULSER];
   assign bus.chip_id           = cfg_q[CHIP_ID_LSB +: CHIP_ID_W];
   assign bus.cfg_valid         = cfg_valid_q;
   assign bus.frame_err         = frame_err_q;

endmodule

// File: tb/tb_config_reg_rx.sv
// Bench for config_reg_rx: two receivers (IDs 8'h00 and 8'h03) share one
// serial wire. Each sent frame pushes the expected outcome per receiver; a
// negedge monitor pops and compares whenever a receiver pulses.
module tb_config_reg_rx;
   import cfg_pkg::*;

   localparam int          TIMEOUT   = 256;
   localparam int          HALF      = 20;   // 1 us at 20 MHz
   localparam logic [47:0] RESET_CFG = 48'h0001_0000_0000;

   typedef struct packed {
      logic        ok;
      logic [47:0] cfg;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_l = 1'b0;
   logic sinp    = 1'b0;
   logic sclk    = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          last_rise_cyc = 0;
   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [47:0] mdl_cfg [2];
   logic [47:0] exp_cfg [2];
   logic        prev_evt [2];
   logic [47:0] dec_a, dec_b;

   always #25 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   config_reg_rx_if bus_a ();
   config_reg_rx_if bus_b ();

   assign bus_a.sinp = sinp;
   assign bus_a.sclk = sclk;
   assign bus_b.sinp = sinp;
   assign bus_b.sclk = sclk;

   config_reg_rx #(.TIMEOUT(TIMEOUT), .MY_ID(8'h00)) dut_a (
      .clk (clk), .reset_l (reset_l), .bus (bus_a.slave)
   );
   config_reg_rx #(.TIMEOUT(TIMEOUT), .MY_ID(8'h03)) dut_b (
      .clk (clk), .reset_l (reset_l), .bus (bus_b.slave)
   );

   // Decoded outputs reassembled in register field order.
   assign dec_a = {bus_a.chip_id, bus_a.use_odd_pulser, bus_a.testmode_shaper,
                   bus_a.testmode_peak_ext, bus_a.use_even_pulser, bus_a.testmode_csa,
                   bus_a.testmode_core, bus_a.four_usec_l, bus_a.holes,
                   bus_a.pulser_hg_l, bus_a.testmode_peak_hg, bus_a.cfd_disable};
   assign dec_b = {bus_b.chip_id, bus_b.use_odd_pulser, bus_b.testmode_shaper,
                   bus_b.testmode_peak_ext, bus_b.use_even_pulser, bus_b.testmode_csa,
                   bus_b.testmode_core, bus_b.four_usec_l, bus_b.holes,
                   bus_b.pulser_hg_l, bus_b.testmode_peak_hg, bus_b.cfd_disable};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One monitor step for receiver idx, sampled on the falling edge.
   task automatic mon_step(input int idx, input logic rst_n, input logic v,
                           input logic er, input logic [47:0] cq, input logic [47:0] dec);
      exp_t e;
      int   depth;
      if (!rst_n) begin
         exp_cfg[idx]  = RESET_CFG;
         prev_evt[idx] = 1'b0;
         return;
      end
      if (v || er) begin
         depth = (idx == 0) ? q_a.size() : q_b.size();
         if (depth == 0) begin
            check($sformatf("unexpected_event_%0d", idx), 64'({v, er}), 64'(0));
         end else begin
            e = (idx == 0) ? q_a.pop_front() : q_b.pop_front();
            check($sformatf("cfg_valid_%0d", idx), 64'(v), 64'(e.ok));
            check($sformatf("frame_err_%0d", idx), 64'(er), 64'(!e.ok));
            check($sformatf("latency_%0d", idx), 64'(cyc - last_rise_cyc), 64'(TIMEOUT + 4));
            check($sformatf("pulse_width_%0d", idx), 64'(prev_evt[idx]), 64'(0));
            check($sformatf("decoded_%0d", idx), 64'(dec), 64'(e.cfg));
            exp_cfg[idx] = e.cfg;
         end
      end
      check($sformatf("config_q_%0d", idx), 64'(cq), 64'(exp_cfg[idx]));
      prev_evt[idx] = v | er;
   endtask

   always @(negedge clk)
      mon_step(0, reset_l, bus_a.cfg_valid, bus_a.frame_err, bus_a.config_q, dec_a);
   always @(negedge clk)
      mon_step(1, reset_l, bus_b.cfg_valid, bus_b.frame_err, bus_b.config_q, dec_b);

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Predict each receiver's reaction to a completed frame.
   task automatic push_exp(input logic [63:0] data, input int nbits);
      exp_t       e;
      logic [7:0] id;
      logic [7:0] mine;
      id = data[47:40];
      for (int idx = 0; idx < 2; idx++) begin
         mine  = (idx == 0) ? 8'h00 : 8'h03;
         e.ok  = (nbits == 48) && (id == mine || id == 8'hFF);
         e.cfg = e.ok ? data[47:0] : mdl_cfg[idx];
         if (e.ok) mdl_cfg[idx] = data[47:0];
         if (idx == 0) q_a.push_back(e);
         else          q_b.push_back(e);
      end
   endtask

   // Clock out nbits of data MSB first; data changes while sclk is low.
   task automatic shift_out(input logic [63:0] data, input int nbits, input bit record);
      for (int i = nbits - 1; i >= 0; i--) begin
         sinp = data[i];
         sclk = 1'b0;
         wait_clks(HALF);
         sclk = 1'b1;
         if (record && i == 0) begin
            last_rise_cyc = cyc;
            push_exp(data, nbits);
         end
         wait_clks(HALF);
      end
   endtask

   task automatic send_frame(input logic [63:0] data, input int nbits, input bit hold_high);
      int budget;
      shift_out(data, nbits, 1'b1);
      if (!hold_high) sclk = 1'b0;
      budget = TIMEOUT + 100;
      while ((q_a.size() + q_b.size()) != 0 && budget > 0) begin
         wait_clks(1);
         budget--;
      end
      check("frame_drain", 64'(q_a.size() + q_b.size()), 64'(0));
      sclk = 1'b0;
      wait_clks(10);
   endtask

   initial begin
      #(50 * 60000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      mdl_cfg[0] = RESET_CFG;
      mdl_cfg[1] = RESET_CFG;
      wait_clks(4);
      reset_l = 1'b1;
      wait_clks(2);

      check("rst_config_a", 64'(bus_a.config_q), 64'(RESET_CFG));
      check("rst_holes_a", 64'(bus_a.holes), 64'(1));
      check("rst_valid_a", 64'(bus_a.cfg_valid), 64'(0));
      check("rst_err_a", 64'(bus_a.frame_err), 64'(0));
      check("rst_config_b", 64'(bus_b.config_q), 64'(RESET_CFG));
      check("rst_valid_b", 64'(bus_b.cfg_valid), 64'(0));

      // Valid frame for ID 00: A commits, B rejects.
      send_frame(64'h0000_00AA_5555_5555, 48, 1'b0);
      check("cfd_disable_f1", 64'(bus_a.cfd_disable), 64'(30'h1555_5555));
      check("chip_id_f1", 64'(bus_a.chip_id), 64'(8'h00));

      // Wrong lengths: 47 bits, then 49 bits with sclk left high.
      send_frame(64'h0000_00AA_5555_5555, 47, 1'b0);
      send_frame(64'h0001_00AB_CDEF_0123, 49, 1'b1);

      // ID matching: foreign, broadcast, chip 03.
      send_frame(64'h0000_0512_3456_789A, 48, 1'b0);
      send_frame(64'h0000_FF00_F0F0_F0F0, 48, 1'b0);
      send_frame(64'h0000_0380_1234_5678, 48, 1'b0);
      check("chip_id_b_03", 64'(bus_b.chip_id), 64'(8'h03));

      // Reset after 20 bits, then a complete frame.
      shift_out(64'h0000_00FF_1234_5678, 20, 1'b0);
      reset_l = 1'b0;
      sclk    = 1'b0;
      mdl_cfg[0] = RESET_CFG;
      mdl_cfg[1] = RESET_CFG;
      wait_clks(3);
      reset_l = 1'b1;
      wait_clks(TIMEOUT + 50);
      check("abort_config_a", 64'(bus_a.config_q), 64'(RESET_CFG));
      send_frame(64'h0000_0055_AAAA_AAAA, 48, 1'b0);

      // Two frames back to back, gap longer than the timeout.
      send_frame(64'h0000_FF12_3456_789A, 48, 1'b0);
      send_frame(64'h0000_FFFE_DCBA_9876, 48, 1'b0);
      check("b2b_config_a", 64'(bus_a.config_q), 64'(48'hFFFE_DCBA_9876));
      check("b2b_config_b", 64'(bus_b.config_q), 64'(48'hFFFE_DCBA_9876));

      wait_clks(5);
      check("sb_empty", 64'(q_a.size() + q_b.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/config_reg_rx.md
Name: config_reg_rx

Overview:
- On-chip receiving end of the serial configuration interface (sinp/sclk pins).
- Oversamples the pins on the system clock and shifts in a 48-bit frame, MSB first.
- Commits the frame to a parallel configuration register after an idle gap, if the length is exactly 48 and the chip ID matches.
- Drives the decoded static controls: CFD enables, test modes, pulser, polarity, TVC range.

Parameters:
- CFG_W, 48, frame length in bits.
- TIMEOUT, 256, idle clk cycles after the last detected sclk rise that end a frame.
- MY_ID, 8'h00, this chip's ID, matched against frame bits [47:40].
- BCAST_ID, 8'hFF, ID accepted by every chip.
- RESET_CFG, 48'h0001_0000_0000, register value after reset (HOLES=1, everything else 0).

Ports:
- clk  in  1  system clock, at least 4x the sclk rate.
- reset_l  in  1  asynchronous active-low reset.
- sinp  in  1  serial data pin, asynchronous to clk.
- sclk  in  1  serial clock pin, asynchronous to clk.
- config_q  out  48  committed configuration register.
- cfd_disable  out  30  config_q[29:0]; 1 disables that CFD.
- testmode_peak_hg  out  1  config_q[30].
- pulser_hg_l  out  1  config_q[31]; 0 selects high-gain pulser.
- holes  out  1  config_q[32].
- four_usec_l  out  1  config_q[33].
- testmode_core  out  1  config_q[34].
- testmode_csa  out  1  config_q[35].
- use_even_pulser  out  1  config_q[36].
- testmode_peak_ext  out  1  config_q[37].
- testmode_shaper  out  1  config_q[38].
- use_odd_pulser  out  1  config_q[39].
- chip_id  out  8  config_q[47:40].
- cfg_valid  out  1  one-clk pulse when a frame is committed.
- frame_err  out  1  one-clk pulse when a frame is discarded.

Behaviour:
- Synchronisation and sampling
  - sinp and sclk each pass through a 2-flop synchroniser; sclk also gets an edge register.
  - A sclk rise is detected 3 clks after the pin edge.
  - The synchronised sinp is sampled in the same cycle as the detected rise. Sender setup (≥1 sclk half-period) covers the skew.
- Shift register sr[47:0]: on each detected rise, sr <= {sr[46:0], sinp_s}. The first bit sent lands in sr[47].
- Bit counter: 6 bits, increments per rise, saturates at 63.
- Idle counter: reloads to TIMEOUT on each rise, decrements in SHIFT.
- FSM IDLE
  - Counters are held at 0.
  - A detected rise shifts the bit in, sets count=1 and moves to SHIFT.
- FSM SHIFT
  - Further rises shift and count.
  - When the idle counter reaches 0, move to CHECK.
- FSM CHECK (one clk)
  - Commit if count==48 and sr[47:40] is MY_ID or BCAST_ID: config_q<=sr, cfg_valid=1.
  - Otherwise: frame_err=1, config_q unchanged.
  - Then IDLE; sr is not cleared.
- Commit latency: config_q updates 1 clk after the idle counter expires, i.e. TIMEOUT+1 clks after the last detected rise.
- A rise during CHECK is ignored; the sender's gap guarantees this does not occur in normal use.
- A non-matching, valid-length frame sets frame_err=1, so the same wire can be shared by several chips for diagnostics.
- All decoded outputs are combinational slices of config_q; they never change mid-frame.
- Reset (asynchronous, any state):
  - config_q=RESET_CFG; sr, counters and synchronisers = 0; state=IDLE; cfg_valid=0, frame_err=0.
  - Reset mid-frame discards the partial frame.
- sclk held high indefinitely: no further rises occur, so the timeout still closes the frame.

Decomposition:
- Package cfg_pkg holds:
  - bit-index constants for every field (CFD_DIS_LSB=0, TESTMODE_PEAK_HG=30 … USE_ODD_PULSER=39, CHIP_ID_LSB=40);
  - CFG_W;
  - the FSM state enum {IDLE, SHIFT, CHECK}.
- One natural sub-module, pin_sync_edge: 2-flop synchroniser plus rising-edge detect, instantiated for sclk, with its sync path reused for sinp.

Test Plan:
- Reset with no traffic -> config_q=48'h0001_0000_0000, holes=1, cfg_valid=0, frame_err=0.
- Send 48'h00AA_5555_5555 MSB first, sclk 1 µs high / 1 µs low, clk 20 MHz -> cfg_valid pulses once TIMEOUT+1 clks after the last rise; config_q equals the frame; cfd_disable=30'h15555555.
- Send 47 bits, then go idle -> frame_err pulse; config_q unchanged. Send 49 bits -> frame_err pulse.
- MY_ID=8'h03: frame with ID 8'h05 -> frame_err, no update; ID 8'hFF -> commit; ID 8'h03 -> commit, chip_id=8'h03.
- Assert reset_l low after 20 bits, release, then send a full valid frame -> only the second frame commits; no err pulse from the aborted one.
- Back-to-back frames separated by > TIMEOUT clks -> two cfg_valid pulses; config_q tracks the second frame.
